// File: rtl/butterfly_dit_if.sv
// butterfly_dit_if: sample/twiddle input bundle and result output bundle of the radix-2 DIT butterfly
interface butterfly_dit_if #(
  parameter int X_WIDTH   = 32,
  parameter int TF_WIDTH  = 24,
  parameter int TAG_WIDTH = 8
);
  logic                 x_nd;
  logic [X_WIDTH-1:0]   xa;
  logic [X_WIDTH-1:0]   xb;
  logic [TF_WIDTH-1:0]  tf;
  logic [TAG_WIDTH-1:0] tag_in;
  logic                 y_nd;
  logic [X_WIDTH-1:0]   ya;
  logic [X_WIDTH-1:0]   yb;
  logic [TAG_WIDTH-1:0] tag_out;
  logic                 overflow;
  modport master (
    output x_nd, xa, xb, tf, tag_in,
    input  y_nd, ya, yb, tag_out, overflow
  );
  modport slave (
    input  x_nd, xa, xb, tf, tag_in,
    output y_nd, ya, yb, tag_out, overflow
  );
endinterface

// File: rtl/butterfly_dit.sv
// butterfly_dit: 4-stage pipelined radix-2 DIT butterfly, ya/yb=(xa+/-xb*W)/2 with floor and saturation
module butterfly_dit #(
  parameter int X_WIDTH   = 32,
  parameter int TF_WIDTH  = 24,
  parameter int TF_SHIFT  = 10,
  parameter int TAG_WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  butterfly_dit_if.slave bus
);
  localparam int XW = X_WIDTH / 2;
  localparam int TW = TF_WIDTH / 2;
  localparam int PW = XW + TW;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] HI = SW'(2 ** (XW - 1) - 1);
  localparam logic signed [SW-1:0] LO = ~HI;
  logic                        v1, v2, v3;
  logic [TAG_WIDTH-1:0]        t1, t2, t3;
  logic signed [XW-1:0]        ar1, ai1, br1, bi1, ar2, ai2, ar3, ai3;
  logic signed [TW-1:0]        wr1, wi1;
  logic signed [PW-1:0]        p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]          m_re, m_im;
  logic signed [SW-1:0]        a_re, a_im;
  logic [XW:0]                 r_are, r_aim, r_bre, r_bim;
  // returns {saturated, clamped value}
  function automatic logic [XW:0] sat(input logic signed [SW-1:0] q);
    return (q > HI) ? {1'b1, HI[XW-1:0]} : (q < LO) ? {1'b1, LO[XW-1:0]} : {1'b0, q[XW-1:0]};
  endfunction
  always_comb begin
    a_re  = SW'(ar3) <<< TF_SHIFT;
    a_im  = SW'(ai3) <<< TF_SHIFT;
    r_are = sat((a_re + SW'(m_re)) >>> (TF_SHIFT + 1));
    r_aim = sat((a_im + SW'(m_im)) >>> (TF_SHIFT + 1));
    r_bre = sat((a_re - SW'(m_re)) >>> (TF_SHIFT + 1));
    r_bim = sat((a_im - SW'(m_im)) >>> (TF_SHIFT + 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, v2, v3} <= '0;
      {t1, t2, t3} <= '0;
      {ar1, ai1, br1, bi1, ar2, ai2, ar3, ai3} <= '0;
      {wr1, wi1} <= '0;
      {p_rr, p_ii, p_ri, p_ir} <= '0;
      {m_re, m_im} <= '0;
      bus.y_nd     <= 1'b0;
      bus.ya       <= '0;
      bus.yb       <= '0;
      bus.tag_out  <= '0;
      bus.overflow <= 1'b0;
    end else begin
      v1   <= bus.x_nd;
      t1   <= bus.tag_in;
      ar1  <= bus.xa[X_WIDTH-1:XW];
      ai1  <= bus.xa[XW-1:0];
      br1  <= bus.xb[X_WIDTH-1:XW];
      bi1  <= bus.xb[XW-1:0];
      wr1  <= bus.tf[TF_WIDTH-1:TW];
      wi1  <= bus.tf[TW-1:0];
      v2   <= v1;
      t2   <= t1;
      ar2  <= ar1;
      ai2  <= ai1;
      p_rr <= PW'(br1) * PW'(wr1);
      p_ii <= PW'(bi1) * PW'(wi1);
      p_ri <= PW'(br1) * PW'(wi1);
      p_ir <= PW'(bi1) * PW'(wr1);
      v3   <= v2;
      t3   <= t2;
      ar3  <= ar2;
      ai3  <= ai2;
      m_re <= (PW+1)'(p_rr) - (PW+1)'(p_ii);
      m_im <= (PW+1)'(p_ri) + (PW+1)'(p_ir);
      bus.y_nd     <= v3;
      bus.overflow <= v3 & (r_are[XW] | r_aim[XW] | r_bre[XW] | r_bim[XW]);
      if (v3) begin
        bus.ya      <= {r_are[XW-1:0], r_aim[XW-1:0]};
        bus.yb      <= {r_bre[XW-1:0], r_bim[XW-1:0]};
        bus.tag_out <= t3;
      end
    end
  end
endmodule

// File: tb/tb_butterfly_dit.sv
// tb_butterfly_dit: randomized and directed checks of butterfly_dit against an integer reference model
module tb_butterfly_dit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] h_ya = '0, h_yb = '0;
  logic [7:0]  h_tag = '0;
  butterfly_dit_if #(.X_WIDTH(32), .TF_WIDTH(24), .TAG_WIDTH(8)) bus();
  butterfly_dit #(.X_WIDTH(32), .TF_WIDTH(24), .TF_SHIFT(10), .TAG_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] cx(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction
  function automatic logic [23:0] tw(input int re, input int im);
    return {12'(re), 12'(im)};
  endfunction
  function automatic longint fdiv(input longint n, input longint d);
    longint q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction
  // y = (a*1024 +/- b*W) / 2048 rounded toward -inf, clamped to 16-bit signed
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [23:0] w,
                                output logic [31:0] ya, output logic [31:0] yb, output logic ov);
    logic signed [15:0] ar16 = a[31:16], ai16 = a[15:0], br16 = b[31:16], bi16 = b[15:0];
    logic signed [11:0] wr12 = w[23:12], wi12 = w[11:0];
    longint ar = ar16, ai = ai16, br = br16, bi = bi16, wr = wr12, wi = wi12;
    longint mr = br * wr - bi * wi;
    longint mi = br * wi + bi * wr;
    longint v[4];
    v[0] = fdiv(ar * 1024 + mr, 2048);
    v[1] = fdiv(ai * 1024 + mi, 2048);
    v[2] = fdiv(ar * 1024 - mr, 2048);
    v[3] = fdiv(ai * 1024 - mi, 2048);
    ov = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] > 32767) begin v[i] = 32767; ov = 1'b1; end
      else if (v[i] < -32768) begin v[i] = -32768; ov = 1'b1; end
    end
    ya = {16'(v[0]), 16'(v[1])};
    yb = {16'(v[2]), 16'(v[3])};
  endfunction
  task automatic drive(input logic nd, input logic [31:0] a, input logic [31:0] b,
                       input logic [23:0] w, input logic [7:0] t);
    bus.x_nd = nd; bus.xa = a; bus.xb = b; bus.tf = w; bus.tag_in = t;
  endtask
  // one isolated sample; got = {y_nd seen early, y_nd, ya, yb, tag_out, overflow} four edges after capture
  task automatic apply_one(input logic [31:0] a, input logic [31:0] b, input logic [23:0] w,
                           input logic [7:0] t, output logic [74:0] got);
    logic pre = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, a, b, w, t);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus.x_nd = 1'b0;
      if (i < 4) pre = pre | bus.y_nd;
    end
    got = {pre, bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow};
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow} !== 74'd0)
      begin errors++; $display("FAIL reset_state got=%h exp=0", {bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow}); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, $urandom, $urandom, 24'($urandom), 8'($urandom));
      @(posedge clk); #1;
      checks++;
      if ({bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow} !== 74'd0)
        begin errors++; $display("FAIL idle_inert got=%h exp=0", {bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow}); end
    end
    drive(1'b0, '0, '0, '0, '0);
  endtask
  task automatic test_basic();
    logic [74:0] got, exp;
    apply_one(cx(100, 50), cx(20, -10), tw(1024, 0), 8'h11, got);
    exp = {1'b0, 1'b1, cx(60, 20), cx(40, 30), 8'h11, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL unity_twiddle got=%h exp=%h", got, exp); end
    apply_one(cx(100, 50), cx(20, -10), tw(0, -1024), 8'h22, got);
    exp = {1'b0, 1'b1, cx(45, 15), cx(55, 35), 8'h22, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL minus_j_twiddle got=%h exp=%h", got, exp); end
    apply_one(cx(3, -3), cx(0, 0), tw(1024, 0), 8'h33, got);
    exp = {1'b0, 1'b1, cx(1, -2), cx(1, -2), 8'h33, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL floor_shift got=%h exp=%h", got, exp); end
    h_ya = cx(1, -2); h_yb = cx(1, -2); h_tag = 8'h33;
  endtask
  task automatic test_saturation();
    logic [74:0] got, exp;
    logic [31:0] ea, eb;
    logic eov;
    model(cx(32767, 0), cx(32767, -32767), tw(724, -724), ea, eb, eov);
    apply_one(cx(32767, 0), cx(32767, -32767), tw(724, -724), 8'h44, got);
    exp = {1'b0, 1'b1, ea, eb, 8'h44, eov};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rot45_edge got=%h exp=%h", got, exp); end
    @(posedge clk); #1;
    drive(1'b1, cx(32767, 32767), cx(32767, 32767), tw(2047, 2047), 8'h40);
    @(posedge clk); #1;
    drive(1'b1, cx(100, 50), cx(20, -10), tw(1024, 0), 8'h41);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    exp = {1'b0, 1'b1, cx(16383, 32767), cx(16383, -32768), 8'h40, 1'b1};
    if ({1'b0, bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow} !== exp)
      begin errors++; $display("FAIL saturate got=%h exp=%h", {1'b0, bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow}, exp); end
    @(posedge clk); #1;
    checks++;
    exp = {1'b0, 1'b1, cx(60, 20), cx(40, 30), 8'h41, 1'b0};
    if ({1'b0, bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow} !== exp)
      begin errors++; $display("FAIL overflow_not_sticky got=%h exp=%h", {1'b0, bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow}, exp); end
    @(posedge clk); #1;
    checks++;
    exp = {1'b0, 1'b0, cx(60, 20), cx(40, 30), 8'h41, 1'b0};
    if ({1'b0, bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow} !== exp)
      begin errors++; $display("FAIL hold_after got=%h exp=%h", {1'b0, bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow}, exp); end
    h_ya = cx(60, 20); h_yb = cx(40, 30); h_tag = 8'h41;
  endtask
  // n samples (gap_pct% idle), then 3 idle cycles and 2 more samples; every output cycle compared
  task automatic test_stream(input string name, input int n, input int gap_pct);
    logic [31:0] sa[64], sb[64];
    logic [23:0] sw[64];
    logic [7:0]  st[64];
    bit          sv[64];
    logic [31:0] ea, eb;
    logic        eov;
    logic [73:0] exp, got;
    int total = n + 5;
    for (int k = 0; k < total; k++) begin
      sv[k] = (k < n) ? ($urandom_range(99) >= gap_pct) : (k >= n + 3);
      sa[k] = $urandom; sb[k] = $urandom; sw[k] = 24'($urandom);
      st[k] = 8'(k);
    end
    for (int k = 0; k < total + 4; k++) begin
      @(posedge clk); #1;
      if (k >= 4) begin
        if (sv[k-4]) begin
          model(sa[k-4], sb[k-4], sw[k-4], ea, eb, eov);
          h_ya = ea; h_yb = eb; h_tag = st[k-4];
          exp = {1'b1, ea, eb, st[k-4], eov};
        end else exp = {1'b0, h_ya, h_yb, h_tag, 1'b0};
        got = {bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL %s cycle=%0d got=%h exp=%h", name, k - 4, got, exp); end
      end
      if (k < total) drive(sv[k], sa[k], sb[k], sw[k], st[k]);
      else drive(1'b0, '0, '0, '0, '0);
    end
  endtask
  task automatic test_reset_midflight();
    logic [74:0] got, exp;
    logic [31:0] ea, eb;
    logic eov;
    @(posedge clk); #1;
    drive(1'b1, cx(1000, -2000), cx(300, 400), tw(1024, 0), 8'hA5);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0, '0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow} !== 74'd0)
      begin errors++; $display("FAIL async_reset got=%h exp=0", {bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow} !== 74'd0)
        begin errors++; $display("FAIL flushed_sample got=%h exp=0", {bus.y_nd, bus.ya, bus.yb, bus.tag_out, bus.overflow}); end
    end
    model(cx(-1234, 567), cx(890, -321), tw(-700, 900), ea, eb, eov);
    apply_one(cx(-1234, 567), cx(890, -321), tw(-700, 900), 8'h5A, got);
    exp = {1'b0, 1'b1, ea, eb, 8'h5A, eov};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL after_reset got=%h exp=%h", got, exp); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_stream("back_to_back", 16, 0);
    test_stream("random", 48, 35);
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
